// File: rtl/sumsq_seq.sv
// Bit-serial sum-of-squares stage: squares |x| and |y| with a shift-add loop.
// It issues x*x + y*y as the radicand to the downstream square-root unit.
module sumsq_seq #(
  parameter int IN_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_WIDTH-1:0]     x,
  input  logic [IN_WIDTH-1:0]     y,
  input  logic                    sqrt_busy,
  output logic                    start,
  output logic [2*IN_WIDTH-1:0]   rad,
  output logic [1:0]              state_dbg
);

  localparam int OUT_W = 2 * IN_WIDTH;
  localparam int IDX_W = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SQ_X  = 2'd1,
    SQ_Y  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t              state_q, state_n;
  logic [OUT_W-1:0]    acc_q, acc_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [IN_WIDTH-1:0] mag_x_q, mag_x_n;
  logic [IN_WIDTH-1:0] mag_y_q, mag_y_n;
  logic                start_q, start_n;
  logic [OUT_W-1:0]    rad_q, rad_n;

  logic [IN_WIDTH-1:0] mag_sel;
  logic [OUT_W-1:0]    addend;
  logic                last_bit;

  // Magnitude of a two's-complement value; the most negative value maps to
  // 2^(IN_WIDTH-1), which still fits as an unsigned IN_WIDTH-bit number.
  function automatic logic [IN_WIDTH-1:0] abs_val(input logic [IN_WIDTH-1:0] v);
    logic [IN_WIDTH-1:0] r;
    r = v[IN_WIDTH-1] ? (~v + {{(IN_WIDTH-1){1'b0}}, 1'b1}) : v;
    return r;
  endfunction

  assign mag_sel  = (state_q == SQ_Y) ? mag_y_q : mag_x_q;
  assign addend   = {{IN_WIDTH{1'b0}}, mag_sel} << idx_q;
  assign last_bit = (idx_q == IDX_W'(IN_WIDTH - 1));

  // Handshake: a pair is taken on any rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and start is a single-cycle pulse that the
  // block raises only when sqrt_busy is low in ISSUE.
  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    idx_n   = idx_q;
    mag_x_n = mag_x_q;
    mag_y_n = mag_y_q;
    start_n = 1'b0;
    rad_n   = rad_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_x_n = abs_val(x);
          mag_y_n = abs_val(y);
          acc_n   = '0;
          idx_n   = '0;
          state_n = SQ_X;
        end
      end
      SQ_X, SQ_Y: begin
        if (mag_sel[idx_q]) begin
          acc_n = acc_q + addend;
        end
        if (last_bit) begin
          idx_n   = '0;
          state_n = (state_q == SQ_X) ? SQ_Y : ISSUE;
        end else begin
          idx_n = idx_q + 1'b1;
        end
      end
      ISSUE: begin
        if (!sqrt_busy) begin
          start_n = 1'b1;
          rad_n   = acc_q;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      mag_x_q <= '0;
      mag_y_q <= '0;
      start_q <= 1'b0;
      rad_q   <= '0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      idx_q   <= idx_n;
      mag_x_q <= mag_x_n;
      mag_y_q <= mag_y_n;
      start_q <= start_n;
      rad_q   <= rad_n;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign start     = start_q;
  assign rad       = rad_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sumsq_seq.sv
// Directed bench for sumsq_seq (IN_WIDTH = 8): latency, extremes, busy
// back-pressure, back-to-back acceptance and reset during computation.
module tb_sumsq_seq;

  localparam int N = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic          sqrt_busy;
  logic          start;
  logic [2*N-1:0] rad;
  logic [1:0]    state_dbg;

  int checks;
  int errors;

  sumsq_seq #(.IN_WIDTH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .sqrt_busy (sqrt_busy),
    .start     (start),
    .rad       (rad),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one pair in the current cycle (A); returns at the negedge of A+1.
  task automatic send_pair(input int xv, input int yv);
    int xi, yi;
    xi = xv;
    yi = yv;
    in_valid = 1'b1;
    x = xi[N-1:0];
    y = yi[N-1:0];
    @(negedge clk);
    in_valid = 1'b0;
    x = N'($urandom_range(0, 255));
    y = N'($urandom_range(0, 255));
  endtask

  // Counts cycles from A+1 until start is seen; -1 if it never arrives.
  task automatic wait_start(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      if (start) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sqrt_busy = 1'b0;
    x = '0;
    y = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b want 0", start); end
    checks++;
    if (rad !== 16'd0) begin errors++; $display("FAIL reset_rad got %0d want 0", rad); end
    checks++;
    if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic;
    int bad_ready;
    int early_start;
    bad_ready = 0;
    early_start = 0;
    send_pair(3, 4);
    for (int k = 1; k <= 17; k++) begin
      if (in_ready !== 1'b0) bad_ready++;
      if (start !== 1'b0) early_start++;
      if (k == 1) begin
        checks++;
        if (state_dbg !== 2'd1) begin errors++; $display("FAIL basic_state_sqx got %0d want 1", state_dbg); end
      end
      if (k == 9) begin
        checks++;
        if (state_dbg !== 2'd2) begin errors++; $display("FAIL basic_state_sqy got %0d want 2", state_dbg); end
      end
      if (k == 17) begin
        checks++;
        if (state_dbg !== 2'd3) begin errors++; $display("FAIL basic_state_issue got %0d want 3", state_dbg); end
      end
      @(negedge clk);
    end
    checks++;
    if (bad_ready !== 0) begin errors++; $display("FAIL basic_busy_ready got %0d cycles ready want 0", bad_ready); end
    checks++;
    if (early_start !== 0) begin errors++; $display("FAIL basic_early_start got %0d want 0", early_start); end
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL basic_start_a18 got %0b want 1", start); end
    checks++;
    if (rad !== 16'd25) begin errors++; $display("FAIL basic_rad got %0d want 25", rad); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_a18 got %0b want 1", in_ready); end
    @(negedge clk);
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL basic_single_pulse got %0b want 0", start); end
    checks++;
    if (rad !== 16'd25) begin errors++; $display("FAIL basic_rad_hold got %0d want 25", rad); end
  endtask

  task automatic test_values;
    int xs [5] = '{-128, 127, 0, -5, 12};
    int ys [5] = '{-128, -1, 0, 0, -9};
    int exp_r [5] = '{32768, 16130, 0, 25, 225};
    int lat;
    for (int t = 0; t < 5; t++) begin
      send_pair(xs[t], ys[t]);
      wait_start(lat);
      checks++;
      if (lat !== 18) begin errors++; $display("FAIL values_latency[%0d] got %0d want 18", t, lat); end
      checks++;
      if (rad !== 16'(exp_r[t])) begin
        errors++; $display("FAIL values_rad[%0d] got %0d want %0d", t, rad, exp_r[t]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy;
    int early;
    int rad_moved;
    // previous rad from test_values is 225; pair (7,1) gives 50
    early = 0;
    rad_moved = 0;
    sqrt_busy = 1'b1;
    send_pair(7, 1);
    for (int k = 1; k <= 26; k++) begin
      if (start !== 1'b0) early++;
      if (rad !== 16'd225) rad_moved++;
      if (k == 20) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_ready_held got %0b want 0", in_ready); end
      end
      sqrt_busy = (k <= 25);
      @(negedge clk);
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL busy_early_start got %0d want 0", early); end
    checks++;
    if (rad_moved !== 0) begin errors++; $display("FAIL busy_rad_hold got %0d changed cycles want 0", rad_moved); end
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL busy_start_a27 got %0b want 1", start); end
    checks++;
    if (rad !== 16'd50) begin errors++; $display("FAIL busy_rad got %0d want 50", rad); end
    sqrt_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_q[$];
    int pulses;
    int pulse_cyc [3] = '{18, 36, 54};
    exp_q = '{16'd2, 16'd8, 16'd18};
    pulses = 0;
    in_valid = 1'b1;
    x = 8'd1;
    y = 8'd1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (start === 1'b1) begin
        checks++;
        if (pulses >= 3 || k !== pulse_cyc[pulses]) begin
          errors++; $display("FAIL b2b_pulse_cycle got %0d pulse %0d", k, pulses);
        end
        if (exp_q.size() > 0) begin
          checks++;
          if (rad !== exp_q[0]) begin errors++; $display("FAIL b2b_rad got %0d want %0d", rad, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        pulses++;
      end
      if (k == 1) begin x = 8'd2; y = 8'd2; end
      if (k == 19) begin x = 8'd3; y = 8'd3; end
      if (k == 37) in_valid = 1'b0;
    end
    checks++;
    if (pulses !== 3) begin errors++; $display("FAIL b2b_pulse_count got %0d want 3", pulses); end
  endtask

  task automatic test_mid_reset;
    int stray;
    int lat;
    stray = 0;
    send_pair(9, 9);
    for (int k = 1; k < 12; k++) @(negedge clk);
    checks++;
    if (state_dbg !== 2'd2) begin errors++; $display("FAIL midrst_in_sqy got %0d want 2", state_dbg); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %0b want 1", in_ready); end
    checks++;
    if (rad !== 16'd0) begin errors++; $display("FAIL midrst_rad got %0d want 0", rad); end
    for (int k = 0; k < 25; k++) begin
      if (start !== 1'b0) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL midrst_stray_start got %0d want 0", stray); end
    send_pair(6, 8);
    wait_start(lat);
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL midrst_latency got %0d want 18", lat); end
    checks++;
    if (rad !== 16'd100) begin errors++; $display("FAIL midrst_rad_after got %0d want 100", rad); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_values();
    test_busy();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
